// File: rtl/fp_compare_seq.sv
// fp_compare_seq: multi-cycle IEEE-754 compare-and-select unit.
// Classifies (a, b) as lt / eq / gt / unordered and returns max/min,
// resolving magnitude with an MSB-first scan of one bit per cycle.
// Optional feature macro: FP_CMP_EARLY_EXIT_EN
//   defined   -> special pairs bypass the scan and the scan stops at the
//                first differing bit (data-dependent latency)
//   undefined -> every operation scans all DATA_W-1 magnitude bits
//                (constant latency of DATA_W cycles, identical results)
module fp_compare_seq #(
    parameter int DATA_W = 32,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_lt,
    output logic              out_eq,
    output logic              out_gt,
    output logic              out_unord,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_min
);

    localparam int MAN_W = DATA_W - 1 - EXP_W;
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_W - 2);
    localparam logic [DATA_W-1:0] QNAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;
    typedef enum logic [1:0] {RES_LT, RES_EQ, RES_GT, RES_UN} res_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] opA_q, opA_d;
    logic [DATA_W-1:0] opB_q, opB_d;
    logic              lt_q, lt_d;
    logic              eq_q, eq_d;
    logic              gt_q, gt_d;
    logic              unord_q, unord_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [DATA_W-1:0] min_q, min_d;

`ifndef FP_CMP_EARLY_EXIT_EN
    // Without early exit the decision is remembered while the scan runs on.
    logic              decided_q, decided_d;
    res_t              code_q, code_d;
`endif

    logic              inSpecial;
    res_t              inCode;
    logic              scanDiff;
    res_t              scanCode;
    logic              loadRes;
    res_t              loadCode;
    logic [DATA_W-1:0] loadA;
    logic [DATA_W-1:0] loadB;

    function automatic logic isNan(input logic [DATA_W-1:0] x);
        return (&x[DATA_W-2 -: EXP_W]) && (|x[MAN_W-1:0]);
    endfunction

    function automatic logic isZero(input logic [DATA_W-1:0] x);
        return ~|x[DATA_W-2:0];
    endfunction

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_lt    = lt_q;
    assign out_eq    = eq_q;
    assign out_gt    = gt_q;
    assign out_unord = unord_q;
    assign out_max   = max_q;
    assign out_min   = min_q;

    // Classify pairs whose answer does not need a magnitude scan.
    always_comb begin
        inSpecial = 1'b0;
        inCode    = RES_EQ;
        if (isNan(in_a) || isNan(in_b)) begin
            inSpecial = 1'b1;
            inCode    = RES_UN;
        end else if (isZero(in_a) && isZero(in_b)) begin
            inSpecial = 1'b1;
            inCode    = RES_EQ;
        end else if (in_a[DATA_W-1] != in_b[DATA_W-1]) begin
            inSpecial = 1'b1;
            inCode    = in_a[DATA_W-1] ? RES_LT : RES_GT;
        end
    end

    // Current scan bit: the operand holding the 1 has the larger magnitude,
    // which means the smaller value when both operands are negative.
    always_comb begin
        scanDiff = opA_q[idx_q] ^ opB_q[idx_q];
        scanCode = (opA_q[idx_q] ^ opA_q[DATA_W-1]) ? RES_GT : RES_LT;
    end

    // Next-state logic for the IDLE -> SCAN -> DONE sequence and result load.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        lt_d     = lt_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        unord_d  = unord_q;
        max_d    = max_q;
        min_d    = min_q;
        loadRes  = 1'b0;
        loadCode = RES_EQ;
        loadA    = opA_q;
        loadB    = opB_q;
`ifndef FP_CMP_EARLY_EXIT_EN
        decided_d = decided_q;
        code_d    = code_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    opA_d = in_a;
                    opB_d = in_b;
`ifdef FP_CMP_EARLY_EXIT_EN
                    if (inSpecial) begin
                        state_d  = ST_DONE;
                        loadRes  = 1'b1;
                        loadCode = inCode;
                        loadA    = in_a;
                        loadB    = in_b;
                    end else begin
                        state_d = ST_SCAN;
                        idx_d   = IDX_TOP;
                    end
`else
                    state_d   = ST_SCAN;
                    idx_d     = IDX_TOP;
                    decided_d = inSpecial;
                    code_d    = inCode;
`endif
                end
            end

            ST_SCAN: begin
`ifdef FP_CMP_EARLY_EXIT_EN
                if (scanDiff || (idx_q == '0)) begin
                    state_d  = ST_DONE;
                    loadRes  = 1'b1;
                    loadCode = scanDiff ? scanCode : RES_EQ;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
`else
                if (!decided_q && scanDiff) begin
                    decided_d = 1'b1;
                    code_d    = scanCode;
                end
                if (idx_q == '0) begin
                    state_d  = ST_DONE;
                    loadRes  = 1'b1;
                    loadCode = decided_q ? code_q : (scanDiff ? scanCode : RES_EQ);
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
`endif
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    unord_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (loadRes) begin
            lt_d    = (loadCode == RES_LT);
            eq_d    = (loadCode == RES_EQ);
            gt_d    = (loadCode == RES_GT);
            unord_d = (loadCode == RES_UN);
            case (loadCode)
                RES_UN: begin
                    max_d = QNAN;
                    min_d = QNAN;
                end
                RES_LT: begin
                    max_d = loadB;
                    min_d = loadA;
                end
                default: begin
                    max_d = loadA;
                    min_d = loadB;
                end
            endcase
        end
    end

    // State and result registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            opA_q   <= '0;
            opB_q   <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            unord_q <= 1'b0;
            max_q   <= '0;
            min_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            unord_q <= unord_d;
            max_q   <= max_d;
            min_q   <= min_d;
        end
    end

`ifndef FP_CMP_EARLY_EXIT_EN
    // Pending decision carried through the full-length scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decided_q <= 1'b0;
            code_q    <= RES_EQ;
        end else begin
            decided_q <= decided_d;
            code_q    <= code_d;
        end
    end
`endif

endmodule
